// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: next-PC predictor with a tagged direct-mapped BTB and a
// gshare PHT of 2-bit saturating counters indexed by PC ^ global history.
// Lookup is combinational on fetch_pc; resolution from EX updates state at clk.
// Optional macro GSHARE_SPEC_HIST_EN: speculative GHR update at fetch with
// mispredict-driven recovery. When it is undefined, the GHR shifts at resolution.
module gshare_btb_predictor #(
   parameter int HIST_LEN     = 5,
   parameter int BTB_IDX_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         fetch_pc,
   input  logic                fetch_advance,
   output logic                pred_taken,
   output logic [31:0]         pred_next_pc,
   output logic [HIST_LEN-1:0] pred_hist,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic                upd_is_branch,
   input  logic                upd_is_jump,
   input  logic                upd_taken,
   input  logic [31:0]         upd_target,
   input  logic [HIST_LEN-1:0] upd_hist,
   input  logic                upd_mispredict,
   output logic [31:0]         mispredict_cnt
);

   localparam int PHT_N = 1 << HIST_LEN;
   localparam int BTB_N = 1 << BTB_IDX_BITS;
   localparam int TAG_W = 30 - BTB_IDX_BITS;

   logic             btb_valid  [BTB_N];
   logic [TAG_W-1:0] btb_tag    [BTB_N];
   logic [31:0]      btb_target [BTB_N];
   logic             btb_jump   [BTB_N];
   logic [1:0]       pht        [PHT_N];
   logic [HIST_LEN-1:0] ghr, ghr_next;

   // ---------------- lookup ----------------
   logic [BTB_IDX_BITS-1:0] f_bidx;
   logic [HIST_LEN-1:0]     f_pidx;
   logic                    f_hit;

   assign f_bidx = fetch_pc[BTB_IDX_BITS+1:2];
   assign f_pidx = fetch_pc[HIST_LEN+1:2] ^ ghr;
   assign f_hit  = btb_valid[f_bidx] && (btb_tag[f_bidx] == fetch_pc[31:BTB_IDX_BITS+2]);

   // Jumps always redirect on a hit; branches follow the PHT counter's MSB.
   always_comb begin
      pred_taken = 1'b0;
      if (f_hit)
         pred_taken = btb_jump[f_bidx] ? 1'b1 : pht[f_pidx][1];
   end

   assign pred_next_pc = pred_taken ? btb_target[f_bidx] : fetch_pc + 32'd4;
   assign pred_hist    = ghr;

   // ---------------- resolution ----------------
   logic [BTB_IDX_BITS-1:0] u_bidx;
   logic [HIST_LEN-1:0]     u_pidx;
   logic                    u_btb_wr, u_pht_wr;

   assign u_bidx   = upd_pc[BTB_IDX_BITS+1:2];
   assign u_pidx   = upd_pc[HIST_LEN+1:2] ^ upd_hist;
   assign u_btb_wr = upd_valid && (upd_is_jump || (upd_is_branch && upd_taken));
   assign u_pht_wr = upd_valid && upd_is_branch;

   // BTB: only valid bits need clearing; a taken CF instruction replaces the occupant.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      end else if (u_btb_wr) begin
         btb_valid[u_bidx]  <= 1'b1;
         btb_tag[u_bidx]    <= upd_pc[31:BTB_IDX_BITS+2];
         btb_target[u_bidx] <= upd_target;
         btb_jump[u_bidx]   <= upd_is_jump;
      end
   end

   // PHT: saturating 2-bit counters, reset to weakly not-taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      end else if (u_pht_wr) begin
         if (upd_taken && pht[u_pidx] != 2'b11)
            pht[u_pidx] <= pht[u_pidx] + 2'b01;
         else if (!upd_taken && pht[u_pidx] != 2'b00)
            pht[u_pidx] <= pht[u_pidx] - 2'b01;
      end
   end

`ifdef GSHARE_SPEC_HIST_EN
   // Recovery from the carried snapshot beats speculative shift at fetch.
   always_comb begin
      ghr_next = ghr;
      if (upd_valid && upd_mispredict && upd_is_branch)
         ghr_next = {upd_hist[HIST_LEN-2:0], upd_taken};
      else if (upd_valid && upd_mispredict && upd_is_jump)
         ghr_next = upd_hist;
      else if (fetch_advance && f_hit && !btb_jump[f_bidx])
         ghr_next = {ghr[HIST_LEN-2:0], pred_taken};
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, fetch_pc[1:0], upd_pc[1:0]};
`else
   // Non-speculative: history only learns actual branch outcomes.
   always_comb begin
      ghr_next = ghr;
      if (upd_valid && upd_is_branch)
         ghr_next = {ghr[HIST_LEN-2:0], upd_taken};
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, fetch_pc[1:0], upd_pc[1:0], fetch_advance};
`endif

   // GHR register; reset overrides any same-cycle update.
   always_ff @(posedge clk) begin
      if (reset) ghr <= '0;
      else       ghr <= ghr_next;
   end

   // Mispredict counter, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset)
         mispredict_cnt <= '0;
      else if (upd_valid && upd_mispredict && mispredict_cnt != 32'hFFFF_FFFF)
         mispredict_cnt <= mispredict_cnt + 32'd1;
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor (HIST_LEN=5, BTB_IDX_BITS=5).
// Build with GSHARE_SPEC_HIST_EN defined to exercise the speculative-history path.
module tb_gshare_btb_predictor;
   localparam int HL = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   fetch_pc;
   logic          fetch_advance;
   logic          pred_taken;
   logic [31:0]   pred_next_pc;
   logic [HL-1:0] pred_hist;
   logic          upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
   logic [31:0]   upd_pc, upd_target;
   logic [HL-1:0] upd_hist;
   logic [31:0]   mispredict_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gshare_btb_predictor #(.HIST_LEN(HL), .BTB_IDX_BITS(5)) dut (
      .clk(clk), .reset(reset),
      .fetch_pc(fetch_pc), .fetch_advance(fetch_advance),
      .pred_taken(pred_taken), .pred_next_pc(pred_next_pc), .pred_hist(pred_hist),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_hist(upd_hist), .upd_mispredict(upd_mispredict),
      .mispredict_cnt(mispredict_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd_clr();
      upd_valid = 0; upd_is_branch = 0; upd_is_jump = 0; upd_taken = 0;
      upd_pc = '0; upd_target = '0; upd_hist = '0; upd_mispredict = 0;
   endtask

   task automatic upd_set(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt,
                          input logic [HL-1:0] hist, input logic misp);
      upd_valid = 1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
      upd_taken = tk; upd_target = tgt; upd_hist = hist; upd_mispredict = misp;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                      input logic tk, input logic [31:0] tgt,
                      input logic [HL-1:0] hist, input logic misp);
      upd_set(pc, br, jmp, tk, tgt, hist, misp);
      tick();
      upd_clr();
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_npc);
      fetch_pc = pc;
      #1;
      chk({tag, "_tk"}, {31'b0, pred_taken}, {31'b0, exp_tk});
      chk({tag, "_npc"}, pred_next_pc, exp_npc);
   endtask

   initial begin
      reset = 1; fetch_pc = 32'h40; fetch_advance = 0;
      upd_clr();
      tick(); tick();
      reset = 0;

      // Reset state
      look("rst", 32'h40, 0, 32'h44);
      chk("rst_hist", {27'b0, pred_hist}, 32'h0);
      chk("rst_cnt", mispredict_cnt, 32'h0);

      // jal at 0x10 -> 0x80; same-cycle lookup sees the old (empty) entry
      fetch_pc = 32'h10;
      upd_set(32'h10, 0, 1, 1, 32'h80, '0, 0);
      #1;
      chk("same_cycle_old", {31'b0, pred_taken}, 32'h0);
      tick();
      upd_clr();
      look("jal_hit", 32'h10, 1, 32'h80);
      look("jal_alias", 32'h90, 0, 32'h94);

`ifndef GSHARE_SPEC_HIST_EN
      // Taken branch 0x20 -> 0x100, hist 0: PHT[8] 01->10, GHR=00001
      upd(32'h20, 1, 0, 1, 32'h100, '0, 0);
      chk("br_hist1", {27'b0, pred_hist}, 32'h1);
      look("br_idx9", 32'h20, 0, 32'h24);          // PHT[8^1] still 01
      upd(32'h20, 1, 0, 1, 32'h100, '0, 0);         // PHT[8] -> 11
      upd(32'h20, 1, 0, 1, 32'h100, '0, 0);         // stays 11 (saturate)
      chk("br_hist7", {27'b0, pred_hist}, 32'h7);
      // Flush GHR with not-taken branches at 0x40 (PHT[16])
      repeat (5) upd(32'h40, 1, 0, 0, 32'h0, '0, 0);
      chk("ghr_flush", {27'b0, pred_hist}, 32'h0);
      look("br_taken", 32'h20, 1, 32'h100);
      // Not-taken updates: 11->10 (still taken, BTB target untouched)
      upd(32'h20, 1, 0, 0, 32'h0, '0, 0);
      look("br_nt1", 32'h20, 1, 32'h100);
      upd(32'h20, 1, 0, 0, 32'h0, '0, 0);           // 01
      upd(32'h20, 1, 0, 0, 32'h0, '0, 0);           // 00
      upd(32'h20, 1, 0, 0, 32'h0, '0, 0);           // stays 00
      look("br_nt_sat", 32'h20, 0, 32'h24);
      chk("nt_hist", {27'b0, pred_hist}, 32'h0);
`else
      // Train PHT[8] and PHT[9] to 10 with correctly predicted taken branches
      upd(32'h20, 1, 0, 1, 32'h100, 5'h0, 0);
      upd(32'h20, 1, 0, 1, 32'h100, 5'h1, 0);
      chk("spec_no_shift", {27'b0, pred_hist}, 32'h0);
      fetch_pc = 32'h20; fetch_advance = 1;
      #1;
      chk("spec_pred0", {31'b0, pred_taken}, 32'h1);
      tick();
      chk("spec_hist1", {27'b0, pred_hist}, 32'h1);
      chk("spec_pred1", {31'b0, pred_taken}, 32'h1);
      tick();
      fetch_advance = 0;
      chk("spec_hist3", {27'b0, pred_hist}, 32'h3);
      // Mispredict recovery in the same cycle as a fetch_advance on a hit
      fetch_advance = 1;
      upd(32'h20, 1, 0, 0, 32'h0, 5'h0, 1);
      fetch_advance = 0;
      chk("spec_recover", {27'b0, pred_hist}, 32'h0);
      // Jump mispredict restores the snapshot unshifted
      upd(32'h10, 0, 1, 1, 32'h80, 5'h15, 1);
      chk("spec_jmp_rec", {27'b0, pred_hist}, 32'h15);
      // fetch_advance on a jump hit leaves GHR alone
      fetch_pc = 32'h10; fetch_advance = 1;
      tick();
      fetch_advance = 0;
      chk("spec_jmp_fetch", {27'b0, pred_hist}, 32'h15);
`endif

      // Mispredict counter from a clean reset
      reset = 1; tick(); reset = 0;
      chk("cnt_rst", mispredict_cnt, 32'h0);
      look("btb_rst", 32'h10, 0, 32'h14);
      repeat (4) upd(32'h0, 0, 0, 0, 32'h0, 5'h0, 1);
      upd(32'h10, 0, 1, 1, 32'h80, 5'h0, 1);       // fifth, also refills BTB
      upd_mispredict = 1; tick(); upd_mispredict = 0; // not valid: no count
      chk("cnt5", mispredict_cnt, 32'h5);
      chk("cnt_hist", {27'b0, pred_hist}, 32'h0);
      look("refill", 32'h10, 1, 32'h80);

      // Reset mid-stream overrides a same-cycle update
      upd_set(32'h30, 0, 1, 1, 32'h200, 5'h0, 1);
      reset = 1;
      tick();
      reset = 0;
      upd_clr();
      chk("mid_rst_cnt", mispredict_cnt, 32'h0);
      look("mid_rst_btb", 32'h10, 0, 32'h14);
      look("mid_rst_upd", 32'h30, 0, 32'h34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
